// File: rtl/sevenseg_decoder.sv
// Passive monitor for a multiplexed active-low seven-segment bus; rebuilds the shown digits
// into a nibble word with blank/illegal flags and a stalled-scan indicator. Optional: SEVENSEG_HEX_DECODE_EN.
module sevenseg_decoder #(
  parameter int NUM_DIGITS     = 4,
  parameter int BITS           = 16,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 2**22
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_DIGITS-1:0] anode,
  input  logic [6:0]            cathode,
  output logic [BITS-1:0]       decoded,
  output logic [NUM_DIGITS-1:0] blank,
  output logic [NUM_DIGITS-1:0] digit_err,
  output logic                  frame_valid,
  output logic                  frame_changed,
  output logic                  stale
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] SETTLE_M1  = CW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT_CYCLES);

  // Returns {illegal, blank, nibble} for an active-low {g..a} pattern.
  function automatic logic [5:0] seg_decode(input logic [6:0] pat);
    logic [5:0] r;
    case (pat)
      7'b1000000: r = 6'b00_0000;
      7'b1111001: r = 6'b00_0001;
      7'b0100100: r = 6'b00_0010;
      7'b0110000: r = 6'b00_0011;
      7'b0011001: r = 6'b00_0100;
      7'b0010010: r = 6'b00_0101;
      7'b0000010: r = 6'b00_0110;
      7'b1111000: r = 6'b00_0111;
      7'b0000000: r = 6'b00_1000;
      7'b0010000: r = 6'b00_1001;
`ifdef SEVENSEG_HEX_DECODE_EN
      7'b0001000: r = 6'b00_1010;
      7'b0000011: r = 6'b00_1011;
      7'b1000110: r = 6'b00_1100;
      7'b0100001: r = 6'b00_1101;
      7'b0000110: r = 6'b00_1110;
      7'b0001110: r = 6'b00_1111;
`endif
      7'b1111111: r = 6'b01_0000;
      default:    r = 6'b10_0000;
    endcase
    return r;
  endfunction

  logic [NUM_DIGITS-1:0] s_anode_q;
  logic [6:0]            s_cathode_q;
  logic [CW-1:0]         stab_q, stab_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic [BITS-1:0]       shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] sh_blank_q, sh_blank_d;
  logic [NUM_DIGITS-1:0] sh_err_q, sh_err_d;
  logic [BITS-1:0]       decoded_q, decoded_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic [NUM_DIGITS-1:0] err_q, err_d;
  logic                  fv_q, fv_d;
  logic                  fc_q, fc_d;
  logic [TW-1:0]         to_q, to_d;
  logic                  stale_q, stale_d;

  logic                  same;
  logic [IW:0]           zeros;
  logic [IW-1:0]         sel_idx;
  logic [NUM_DIGITS-1:0] sel_bit;
  logic                  capture;
  logic                  frame_done;
  logic [5:0]            dec;

  // Locate the single active anode; more than one low bit means the bus is mid-transition.
  always_comb begin
    zeros   = '0;
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!s_anode_q[i]) begin
        zeros   = zeros + {{IW{1'b0}}, 1'b1};
        sel_idx = i[IW-1:0];
      end
    end
  end

  always_comb begin
    same       = ({anode, cathode} == {s_anode_q, s_cathode_q});
    stab_d     = !same ? '0 : ((stab_q == SETTLE_MAX) ? stab_q : stab_q + 1'b1);
    capture    = same && (stab_q == SETTLE_M1) && (zeros == {{IW{1'b0}}, 1'b1});
    dec        = seg_decode(s_cathode_q);
    sel_bit    = '0;
    sel_bit[sel_idx] = 1'b1;

    shadow_d   = shadow_q;
    sh_blank_d = sh_blank_q;
    sh_err_d   = sh_err_q;
    mask_d     = mask_q;
    frame_done = 1'b0;
    if (capture) begin
      shadow_d[sel_idx*4 +: 4] = dec[3:0];
      sh_blank_d[sel_idx]      = dec[4];
      sh_err_d[sel_idx]        = dec[5];
      mask_d                   = mask_q | sel_bit;
      frame_done               = &mask_d;
      if (frame_done) mask_d = '0;
    end

    decoded_d = decoded_q;
    blank_d   = blank_q;
    err_d     = err_q;
    fv_d      = frame_done;
    fc_d      = 1'b0;
    if (frame_done) begin
      decoded_d = shadow_d;
      blank_d   = sh_blank_d;
      err_d     = sh_err_d;
      fc_d      = (shadow_d != decoded_q);
    end

    // Timeout keeps counting across partial frames; only a completed frame restarts it.
    to_d    = frame_done ? '0 : ((to_q == TO_MAX) ? to_q : to_q + 1'b1);
    stale_d = !frame_done && (to_d == TO_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_anode_q   <= '0;
      s_cathode_q <= '0;
      stab_q      <= '0;
      mask_q      <= '0;
      shadow_q    <= '0;
      sh_blank_q  <= '0;
      sh_err_q    <= '0;
      decoded_q   <= '0;
      blank_q     <= '0;
      err_q       <= '0;
      fv_q        <= 1'b0;
      fc_q        <= 1'b0;
      to_q        <= '0;
      stale_q     <= 1'b0;
    end else begin
      s_anode_q   <= anode;
      s_cathode_q <= cathode;
      stab_q      <= stab_d;
      mask_q      <= mask_d;
      shadow_q    <= shadow_d;
      sh_blank_q  <= sh_blank_d;
      sh_err_q    <= sh_err_d;
      decoded_q   <= decoded_d;
      blank_q     <= blank_d;
      err_q       <= err_d;
      fv_q        <= fv_d;
      fc_q        <= fc_d;
      to_q        <= to_d;
      stale_q     <= stale_d;
    end
  end

  assign decoded       = decoded_q;
  assign blank         = blank_q;
  assign digit_err     = err_q;
  assign frame_valid   = fv_q;
  assign frame_changed = fc_q;
  assign stale         = stale_q;

endmodule
